stream_demux4: RTL and testbench

Single-input, four-output valid/ready stream demultiplexer. It is the distribution-side counterpart of the 4:1 selector: each input beat carries a 2-bit destination select and is routed into a per-destination 2-entry FIFO. Each output drains independently, so a stalled destination never blocks traffic to the other three unless that traffic targets the stalled one. It sits between a single producer and up to four consumers in the lab datapath.

---
 rtl/stream_demux4.sv | 99 +++++++++
 tb/tb_stream_demux4.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/stream_demux4.sv
// Single-input, four-output valid/ready stream demultiplexer.
// Each beat is steered by in_sel into a private 2-entry FIFO that drains on its own.
module stream_demux4 #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned DEPTH  = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [1:0]            in_sel,
    input  logic [DATA_W-1:0]     in_data,
    output logic [3:0]            out_valid,
    input  logic [3:0]            out_ready,
    output logic [4*DATA_W-1:0]   out_data,
    output logic [11:0]           count,
    output logic [15:0]           beats_in
);

    localparam int unsigned NumOut = 4;

    logic [DATA_W-1:0] mem_q  [NumOut][DEPTH];
    logic [DATA_W-1:0] last_q [NumOut];
    logic [1:0]        cnt_q  [NumOut];
    logic [1:0]        cnt_d  [NumOut];
    logic [NumOut-1:0] wr_ptr_q, wr_ptr_d;
    logic [NumOut-1:0] rd_ptr_q, rd_ptr_d;
    logic [NumOut-1:0] push, pop;
    logic [15:0]       beats_q, beats_d;

    // Readiness depends only on the selected FIFO's occupancy, never on out_ready.
    assign in_ready = (cnt_q[in_sel] != 2'(DEPTH));

    always_comb begin
        push = '0;
        pop  = '0;
        for (int k = 0; k < NumOut; k++) begin
            push[k] = in_valid & in_ready & (in_sel == 2'(k));
            pop[k]  = (cnt_q[k] != 2'd0) & out_ready[k];
        end
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q ^ push;
        rd_ptr_d = rd_ptr_q ^ pop;
        beats_d  = (|push) ? beats_q + 16'd1 : beats_q;
        for (int k = 0; k < NumOut; k++) begin
            cnt_d[k] = cnt_q[k];
            if (push[k] && !pop[k]) begin
                cnt_d[k] = cnt_q[k] + 2'd1;
            end else if (pop[k] && !push[k]) begin
                cnt_d[k] = cnt_q[k] - 2'd1;
            end
        end
    end

    always_comb begin
        out_valid = '0;
        out_data  = '0;
        count     = '0;
        for (int k = 0; k < NumOut; k++) begin
            out_valid[k]               = (cnt_q[k] != 2'd0);
            // An empty FIFO shows the last value it handed out.
            out_data[k*DATA_W +: DATA_W] = (cnt_q[k] != 2'd0) ? mem_q[k][rd_ptr_q[k]] : last_q[k];
            count[3*k +: 3]            = {1'b0, cnt_q[k]};
        end
    end

    assign beats_in = beats_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            beats_q  <= '0;
            for (int k = 0; k < NumOut; k++) begin
                cnt_q[k]  <= '0;
                last_q[k] <= '0;
                for (int e = 0; e < DEPTH; e++) begin
                    mem_q[k][e] <= '0;
                end
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            beats_q  <= beats_d;
            for (int k = 0; k < NumOut; k++) begin
                cnt_q[k] <= cnt_d[k];
                if (push[k]) begin
                    mem_q[k][wr_ptr_q[k]] <= in_data;
                end
                if (pop[k]) begin
                    last_q[k] <= mem_q[k][rd_ptr_q[k]];
                end
            end
        end
    end

endmodule

// File: tb/tb_stream_demux4.sv
// Directed self-checking bench for stream_demux4.
module tb_stream_demux4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  in_sel;
    logic [7:0]  in_data;
    logic [3:0]  out_valid;
    logic [3:0]  out_ready;
    logic [31:0] out_data;
    logic [11:0] count;
    logic [15:0] beats_in;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    stream_demux4 #(.DATA_W(8), .DEPTH(2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_sel    (in_sel),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .count     (count),
        .beats_in  (beats_in)
    );

    task automatic test_reset();
        in_valid = 0; in_sel = 0; in_data = 0; out_ready = 0;
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        @(negedge clk); #1;
        tests++; if (out_valid !== 4'b0000) begin fails++; $display("FAIL reset_valid got %b want 0000", out_valid); end
        tests++; if (count !== 12'd0) begin fails++; $display("FAIL reset_count got %h want 000", count); end
        tests++; if (beats_in !== 16'd0) begin fails++; $display("FAIL reset_beats got %0d want 0", beats_in); end
        tests++; if (out_data !== 32'd0) begin fails++; $display("FAIL reset_data got %h want 0", out_data); end
        for (int s = 0; s < 4; s++) begin
            in_sel = 2'(s); #1;
            tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL reset_ready sel%0d got %b want 1", s, in_ready); end
        end
        in_sel = 0;
        @(negedge clk); rst_n = 1'b1;
    endtask

    task automatic test_fill();
        logic [7:0] vals [3];
        logic       exp_rdy [3];
        logic [2:0] exp_cnt [3];
        vals = '{8'hA1, 8'hA2, 8'hA3};
        exp_rdy = '{1'b1, 1'b1, 1'b0};
        exp_cnt = '{3'd0, 3'd1, 3'd2};
        out_ready = 4'b0000;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            in_valid = 1; in_sel = 2'd2; in_data = vals[i]; #1;
            tests++; if (in_ready !== exp_rdy[i]) begin fails++; $display("FAIL fill_ready beat%0d got %b want %b", i, in_ready, exp_rdy[i]); end
            tests++; if (count[8:6] !== exp_cnt[i]) begin fails++; $display("FAIL fill_count beat%0d got %0d want %0d", i, count[8:6], exp_cnt[i]); end
        end
        @(negedge clk); #1;
        tests++; if (count[8:6] !== 3'd2) begin fails++; $display("FAIL fill_count_final got %0d want 2", count[8:6]); end
        tests++; if (out_valid !== 4'b0100) begin fails++; $display("FAIL fill_valid got %b want 0100", out_valid); end
        tests++; if (out_data[23:16] !== 8'hA1) begin fails++; $display("FAIL fill_head got %h want a1", out_data[23:16]); end
        tests++; if (beats_in !== 16'd2) begin fails++; $display("FAIL fill_beats got %0d want 2", beats_in); end
    endtask

    // A3 is still offered on sel 2 from test_fill.
    task automatic test_drain();
        out_ready = 4'b0100; #1;
        tests++; if (out_data[23:16] !== 8'hA1 || in_ready !== 1'b0) begin fails++; $display("FAIL drain_c0 got %h/%b want a1/0", out_data[23:16], in_ready); end
        @(negedge clk); #1;
        tests++; if (out_data[23:16] !== 8'hA2 || in_ready !== 1'b1) begin fails++; $display("FAIL drain_c1 got %h/%b want a2/1", out_data[23:16], in_ready); end
        @(negedge clk); #1;
        tests++; if (out_data[23:16] !== 8'hA3 || out_valid !== 4'b0100) begin fails++; $display("FAIL drain_c2 got %h/%b want a3/0100", out_data[23:16], out_valid); end
        tests++; if (beats_in !== 16'd3 || count[8:6] !== 3'd1) begin fails++; $display("FAIL drain_beats got %0d/%0d want 3/1", beats_in, count[8:6]); end
        in_valid = 0;
        @(negedge clk); out_ready = 4'b0000; #1;
        tests++; if (out_valid !== 4'b0000) begin fails++; $display("FAIL drain_empty got %b want 0000", out_valid); end
    endtask

    task automatic test_interleave();
        logic [3:0] exp_v;
        out_ready = 4'b1111;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            in_valid = 1; in_sel = 2'(k); in_data = 8'(10 + k); #1;
            exp_v = (k > 0) ? 4'(1 << (k - 1)) : 4'b0000;
            tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL ilv_ready k%0d got %b want 1", k, in_ready); end
            tests++; if (out_valid !== exp_v) begin fails++; $display("FAIL ilv_valid k%0d got %b want %b", k, out_valid, exp_v); end
            if (k > 0) begin
                tests++; if (out_data[(k-1)*8 +: 8] !== 8'(9 + k)) begin fails++; $display("FAIL ilv_data k%0d got %0d want %0d", k - 1, out_data[(k-1)*8 +: 8], 9 + k); end
            end
        end
        @(negedge clk); in_valid = 0; #1;
        tests++; if (out_valid !== 4'b1000 || out_data[31:24] !== 8'd13) begin fails++; $display("FAIL ilv_last got %b/%0d want 1000/13", out_valid, out_data[31:24]); end
        @(negedge clk); #1;
        tests++; if (out_valid !== 4'b0000) begin fails++; $display("FAIL ilv_empty got %b want 0000", out_valid); end
        out_ready = 4'b0000;
    endtask

    task automatic test_hol();
        logic [1:0] sels [4];
        logic [7:0] dat  [4];
        sels = '{2'd1, 2'd1, 2'd3, 2'd3};
        dat  = '{8'd20, 8'd21, 8'd30, 8'd31};
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            in_valid = 1; in_sel = 2'd1; in_data = 8'd99; #1;
            if (i >= 2) begin
                tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL hol_blocked i%0d got %b want 0", i, in_ready); end
            end
            in_sel = sels[i]; in_data = dat[i]; #1;
            tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL hol_accept i%0d got %b want 1", i, in_ready); end
        end
        @(negedge clk); in_sel = 2'd0; #1;
        tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL hol_sel0 got %b want 1", in_ready); end
        in_valid = 0;
        tests++; if (count !== 12'b010_000_010_000 || out_valid !== 4'b1010) begin fails++; $display("FAIL hol_state got %h/%b want 410/1010", count, out_valid); end
        out_ready = 4'b1111; #1;
        tests++; if (out_data[15:8] !== 8'd20 || out_data[31:24] !== 8'd30) begin fails++; $display("FAIL hol_head0 got %0d/%0d want 20/30", out_data[15:8], out_data[31:24]); end
        @(negedge clk); #1;
        tests++; if (out_data[15:8] !== 8'd21 || out_data[31:24] !== 8'd31) begin fails++; $display("FAIL hol_head1 got %0d/%0d want 21/31", out_data[15:8], out_data[31:24]); end
        @(negedge clk); #1;
        tests++; if (out_valid !== 4'b0000) begin fails++; $display("FAIL hol_empty got %b want 0000", out_valid); end
        out_ready = 4'b0000;
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            out_ready = 4'b0001; in_valid = 1; in_sel = 2'd0; in_data = 8'(i); #1;
            if (i > 0) begin
                tests++; if (count[2:0] !== 3'd1 || out_data[7:0] !== 8'(i - 1) || in_ready !== 1'b1) begin
                    fails++; $display("FAIL b2b i%0d got cnt%0d data%0d rdy%b want cnt1 data%0d rdy1", i, count[2:0], out_data[7:0], in_ready, i - 1);
                end
            end
        end
        @(negedge clk); in_valid = 0; #1;
        tests++; if (out_data[7:0] !== 8'd19 || count[2:0] !== 3'd1) begin fails++; $display("FAIL b2b_last got %0d/%0d want 19/1", out_data[7:0], count[2:0]); end
        tests++; if (beats_in !== 16'd31) begin fails++; $display("FAIL b2b_beats got %0d want 31", beats_in); end
        @(negedge clk); out_ready = 4'b0000; #1;
        tests++; if (out_valid !== 4'b0000) begin fails++; $display("FAIL b2b_empty got %b want 0000", out_valid); end
    endtask

    task automatic test_mid_reset();
        logic [1:0] sels [4];
        sels = '{2'd0, 2'd0, 2'd3, 2'd3};
        out_ready = 4'b0000;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            in_valid = 1; in_sel = sels[i]; in_data = 8'(40 + i);
        end
        @(negedge clk); in_valid = 0; #1;
        tests++; if (count !== 12'b010_000_000_010) begin fails++; $display("FAIL mrst_pre got %h want 402", count); end
        rst_n = 1'b0; #1;
        tests++; if (out_valid !== 4'b0000 || count !== 12'd0 || beats_in !== 16'd0) begin
            fails++; $display("FAIL mrst_clear got %b/%h/%0d want 0000/000/0", out_valid, count, beats_in);
        end
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk); in_valid = 1; in_sel = 2'd2; in_data = 8'h77;
        @(negedge clk); in_valid = 0; #1;
        tests++; if (out_valid !== 4'b0100 || out_data[23:16] !== 8'h77) begin fails++; $display("FAIL mrst_first got %b/%h want 0100/77", out_valid, out_data[23:16]); end
        tests++; if (beats_in !== 16'd1 || count !== 12'b000_001_000_000) begin fails++; $display("FAIL mrst_beats got %0d/%h want 1/040", beats_in, count); end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_drain();
        test_interleave();
        test_hol();
        test_back_to_back();
        test_mid_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
